// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, runtime baud divisor, optional parity,
// one or two stop bits and a line-break mode. tx_o is driven straight from a flop.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_BITS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_BITS-1:0]  divisor_i,
  input  logic                 write_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 break_i,
  output logic                 full_o,
  output logic                 overflow_o,
  output logic                 idle_o,
  output logic                 tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]       PTR_ONE   = AW'(1);
  localparam logic [AW:0]         CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]         CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [DIV_BITS-1:0] DIV_ONE   = DIV_BITS'(1);
  localparam logic [3:0]          LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]          LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 push, pop, empty;

  state_t               state, state_next;
  logic [DIV_BITS-1:0]  cnt, div_q, div_new;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit, tx_next, tick;

  assign empty   = (count == '0);
  assign full_o  = (count == CNT_FULL);
  assign push    = write_i && !full_o;
  assign tick    = (cnt == '0);
  assign div_new = (divisor_i == '0) ? DIV_ONE : divisor_i;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= write_i && full_o;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      S_IDLE: begin
        if (break_i) begin
          state_next = S_BREAK;
        end else if (!empty) begin
          pop        = 1'b1;
          state_next = S_START;
        end
      end
      S_BREAK: begin
        tx_next = 1'b0;
        if (!break_i) state_next = S_IDLE;
      end
      S_START: begin
        tx_next = 1'b0;
        if (tick) state_next = S_DATA;
      end
      S_DATA: begin
        tx_next = shift[0];
        if (tick && bit_cnt == LAST_DATA)
          state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_next = par_bit;
        if (tick) state_next = S_STOP;
      end
      S_STOP: begin
        // Back-to-back frames: the next start bit follows the last stop clock directly.
        if (tick && bit_cnt == LAST_STOP) begin
          if (!empty && !break_i) begin
            pop        = 1'b1;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      div_q   <= DIV_ONE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx_o    <= 1'b1;
      idle_o  <= 1'b1;
    end else begin
      tx_o   <= tx_next;
      idle_o <= empty && (state == S_IDLE) && !break_i;
      if (pop) begin
        shift   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
        div_q   <= div_new;
        cnt     <= div_new - DIV_ONE;
        bit_cnt <= '0;
      end else if (state != S_IDLE && state != S_BREAK) begin
        if (tick) begin
          cnt <= div_q - DIV_ONE;
          if (state == S_DATA) begin
            shift   <= shift >> 1;
            bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
          end else if (state == S_STOP) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          cnt <= cnt - DIV_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random bursts, each frame compared
// clock by clock against a waveform built from the frame format rules.
module tb_uart_tx_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] divisor = 16'd4;
  logic        write_a = 1'b0;
  logic [7:0]  data_a = 8'h00;
  logic        write_b = 1'b0;
  logic [6:0]  data_b = 7'h00;
  logic        brk = 1'b0;

  logic full_a, ovf_a, idle_a, tx_a;
  logic full_e, ovf_e, idle_e, tx_e;
  logic full_d, ovf_d, idle_d, tx_d;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx_fifo dut_a (
    .clock(clock), .reset(reset), .divisor_i(divisor), .write_i(write_a), .data_i(data_a),
    .break_i(brk), .full_o(full_a), .overflow_o(ovf_a), .idle_o(idle_a), .tx_o(tx_a));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_e (
    .clock(clock), .reset(reset), .divisor_i(divisor), .write_i(write_b), .data_i(data_b),
    .break_i(1'b0), .full_o(full_e), .overflow_o(ovf_e), .idle_o(idle_e), .tx_o(tx_e));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_d (
    .clock(clock), .reset(reset), .divisor_i(divisor), .write_i(write_b), .data_i(data_b),
    .break_i(1'b0), .full_o(full_d), .overflow_o(ovf_d), .idle_o(idle_d), .tx_o(tx_d));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      1:       return tx_e;
      2:       return tx_d;
      default: return tx_a;
    endcase
  endfunction

  // Called on the negedge where the first start-bit clock is visible; returns on the
  // negedge just after the last stop-bit clock.
  task automatic check_frame(input int sel, input int div, input logic [8:0] data,
                             input int nbits, input int par, input int nstop);
    logic exp_bits[$];
    int   ones = 0;
    int   d = (div == 0) ? 1 : div;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      exp_bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par == 2) exp_bits.push_back(logic'(ones % 2));
    if (par == 1) exp_bits.push_back(logic'(1 - ones % 2));
    for (int i = 0; i < nstop; i++) exp_bits.push_back(1'b1);
    foreach (exp_bits[b]) begin
      for (int k = 0; k < d; k++) begin
        check_val($sformatf("tx_dut%0d_data%0h_bit%0d", sel, data, b), tx_of(sel), exp_bits[b]);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[6];
    int         n;
    bit         saw;

    repeat (3) @(negedge clock);
    check_val("reset_tx", tx_a, 1);
    check_val("reset_full", full_a, 0);
    check_val("reset_ovf", ovf_a, 0);
    check_val("reset_idle", idle_a, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // single 8N1 frame, divisor 4
    divisor = 16'd4;
    write_a = 1'b1; data_a = 8'hA5;
    @(negedge clock); write_a = 1'b0;
    @(negedge clock); check_val("t1_pre_start", tx_a, 1);
    @(negedge clock);
    check_frame(0, 4, 9'h0A5, 8, 0, 1);
    check_val("t1_idle_after", idle_a, 1);
    repeat (3) @(negedge clock);

    // six consecutive writes: one pops immediately, four fill the FIFO, the sixth overflows
    divisor = 16'd2;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          data_a = 8'(i + 1); write_a = 1'b1;
          @(negedge clock);
        end
        write_a = 1'b0;
        check_val("t2_ovf_pulse", ovf_a, 1);
        check_val("t2_full", full_a, 1);
        @(negedge clock);
        check_val("t2_ovf_clear", ovf_a, 0);
      end
      begin
        @(negedge clock);
        @(negedge clock); check_val("t2_pre_start", tx_a, 1);
        @(negedge clock);
        for (int i = 1; i <= 5; i++) check_frame(0, 2, 9'(i), 8, 0, 1);
        check_val("t2_idle_after", idle_a, 1);
      end
    join
    saw = 1'b0;
    repeat (30) begin @(negedge clock); if (tx_a !== 1'b1) saw = 1'b1; end
    check_val("t2_dropped_not_sent", saw, 0);

    // 7 data bits, even and odd parity, two stop bits, divisor 3
    divisor = 16'd3;
    write_b = 1'b1; data_b = 7'h41;
    @(negedge clock); write_b = 1'b0;
    @(negedge clock);
    check_val("t3_pre_start_e", tx_e, 1);
    check_val("t3_pre_start_d", tx_d, 1);
    @(negedge clock);
    fork
      check_frame(1, 3, 9'h041, 7, 2, 2);
      check_frame(2, 3, 9'h041, 7, 1, 2);
    join
    check_val("t3_idle_e", idle_e, 1);
    check_val("t3_idle_d", idle_d, 1);
    repeat (2) @(negedge clock);

    // divisor 0 acts as 1; a mid-frame divisor change applies only to the next frame
    divisor = 16'd0;
    write_a = 1'b1; data_a = 8'h00;
    fork
      begin
        @(negedge clock); data_a = 8'h3C;
        @(negedge clock); write_a = 1'b0;
        @(negedge clock);
        @(negedge clock); divisor = 16'd8;
      end
      begin
        repeat (3) @(negedge clock);
        check_frame(0, 1, 9'h000, 8, 0, 1);
        check_frame(0, 8, 9'h03C, 8, 0, 1);
      end
    join
    repeat (2) @(negedge clock);

    // break raised during data bit 3 with one byte queued
    divisor = 16'd4;
    write_a = 1'b1; data_a = 8'h5A;
    fork
      begin
        @(negedge clock); data_a = 8'hC3;
        @(negedge clock); write_a = 1'b0;
        repeat (18) @(negedge clock);
        brk = 1'b1;
      end
      begin
        repeat (3) @(negedge clock);
        check_frame(0, 4, 9'h05A, 8, 0, 1);
        check_val("t5_gap_high", tx_a, 1);
        for (int i = 0; i < 8; i++) begin
          @(negedge clock);
          check_val("t5_break_low", tx_a, 0);
        end
        check_val("t5_break_not_idle", idle_a, 0);
        brk = 1'b0;
        @(negedge clock); check_val("t5_release_low", tx_a, 0);
        @(negedge clock); check_val("t5_release_high", tx_a, 1);
        @(negedge clock);
        check_frame(0, 4, 9'h0C3, 8, 0, 1);
      end
    join
    repeat (2) @(negedge clock);

    // reset during DATA with two bytes still queued
    divisor = 16'd4;
    for (int i = 0; i < 3; i++) begin
      data_a = 8'(8'hF0 + i); write_a = 1'b1;
      @(negedge clock);
    end
    write_a = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("t6_tx_after_reset", tx_a, 1);
    check_val("t6_idle_after_reset", idle_a, 1);
    check_val("t6_full_after_reset", full_a, 0);
    saw = 1'b0;
    repeat (120) begin
      @(negedge clock);
      if (tx_a !== 1'b1 || idle_a !== 1'b1) saw = 1'b1;
    end
    check_val("t6_quiet_after_reset", saw, 0);

    // random bursts with random divisors
    for (int r = 0; r < 20; r++) begin
      divisor = 16'($urandom_range(0, 5));
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
      fork
        begin
          for (int i = 0; i < n; i++) begin
            data_a = bytes[i]; write_a = 1'b1;
            @(negedge clock);
          end
          write_a = 1'b0;
        end
        begin
          @(negedge clock);
          @(negedge clock); check_val("rnd_pre_start", tx_a, 1);
          @(negedge clock);
          for (int i = 0; i < n; i++) check_frame(0, int'(divisor), {1'b0, bytes[i]}, 8, 0, 1);
          check_val("rnd_idle_after", idle_a, 1);
        end
      join
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
